// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared MIPS32 pipeline widths, constants and control bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int REG_ADDR_W = 5;
    localparam int IMM_W      = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Control bundle carried down the pipeline; reused by EX/MEM and MEM/WB.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module  : load_use_detect
// Brief   : Combinational load-use hazard comparator for the ID/EX boundary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_uses_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_wr_addr,
    output logic              hazard
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_load_live;

    always_comb begin
        // A load into $0 never produces a value a consumer must wait for.
        w_load_live = ex_valid & ex_mem_read & (ex_wr_addr != ADDR_W'(ZERO_REG));
        w_rs_match  = (ex_wr_addr == id_rs_addr);
        w_rt_match  = id_uses_rt & (ex_wr_addr == id_rt_addr);
        hazard      = id_valid & w_load_live & (w_rs_match | w_rt_match);
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Brief   : MIPS32 ID/EX pipeline register with load-use bubble insertion,
//           branch flush and saturating stall/flush event counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_pc_plus4,
    input  logic [ADDR_W-1:0]   id_rs_addr,
    input  logic [ADDR_W-1:0]   id_rt_addr,
    input  logic [ADDR_W-1:0]   id_rd_addr,
    input  logic                id_uses_rt,
    input  logic [DATA_W-1:0]   rd_data1,
    input  logic [DATA_W-1:0]   rd_data2,
    input  logic [IMM_W-1:0]    id_imm,
    input  logic                id_sign_ext,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                flush,
    output logic                hazard_stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_pc_plus4,
    output logic [DATA_W-1:0]   ex_a,
    output logic [DATA_W-1:0]   ex_b,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [ADDR_W-1:0]   ex_rs_addr,
    output logic [ADDR_W-1:0]   ex_rt_addr,
    output logic [ADDR_W-1:0]   ex_wr_addr,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);

    logic                w_hazard;
    ctrl_t               w_id_ctrl;

    logic                ex_valid_d,    ex_valid_q;
    logic [DATA_W-1:0]   ex_pc_plus4_d, ex_pc_plus4_q;
    logic [DATA_W-1:0]   ex_a_d,        ex_a_q;
    logic [DATA_W-1:0]   ex_b_d,        ex_b_q;
    logic [DATA_W-1:0]   ex_imm_d,      ex_imm_q;
    logic [ADDR_W-1:0]   ex_rs_addr_d,  ex_rs_addr_q;
    logic [ADDR_W-1:0]   ex_rt_addr_d,  ex_rt_addr_q;
    logic [ADDR_W-1:0]   ex_wr_addr_d,  ex_wr_addr_q;
    ctrl_t               ex_ctrl_d,     ex_ctrl_q;
    logic [CNT_W-1:0]    stall_count_d, stall_count_q;
    logic [CNT_W-1:0]    flush_count_d, flush_count_q;

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_uses_rt  (id_uses_rt),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_wr_addr  (ex_wr_addr_q),
        .hazard      (w_hazard)
    );

    // A flushed instruction is discarded anyway, so it must not also freeze IF/ID.
    assign hazard_stall = w_hazard & ~flush;

    always_comb begin
        w_id_ctrl.reg_write  = id_reg_write  & id_valid;
        w_id_ctrl.mem_read   = id_mem_read   & id_valid;
        w_id_ctrl.mem_write  = id_mem_write  & id_valid;
        w_id_ctrl.mem_to_reg = id_mem_to_reg & id_valid;
        w_id_ctrl.alu_src    = id_alu_src    & id_valid;
        w_id_ctrl.alu_op     = id_alu_op     & {ALU_OP_W{id_valid}};

        ex_valid_d    = 1'b0;
        ex_pc_plus4_d = '0;
        ex_a_d        = '0;
        ex_b_d        = '0;
        ex_imm_d      = '0;
        ex_rs_addr_d  = '0;
        ex_rt_addr_d  = '0;
        ex_wr_addr_d  = '0;
        ex_ctrl_d     = '0;

        if (!flush && !w_hazard) begin
            ex_valid_d    = id_valid;
            ex_pc_plus4_d = id_pc_plus4;
            ex_a_d        = rd_data1;
            ex_b_d        = rd_data2;
            ex_imm_d      = {{(DATA_W-IMM_W){id_imm[IMM_W-1] & id_sign_ext}}, id_imm};
            ex_rs_addr_d  = id_rs_addr;
            ex_rt_addr_d  = id_rt_addr;
            ex_wr_addr_d  = id_reg_dst ? id_rd_addr : id_rt_addr;
            ex_ctrl_d     = w_id_ctrl;
        end

        stall_count_d = stall_count_q;
        if (hazard_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end

        flush_count_d = flush_count_q;
        if (flush && id_valid && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_plus4_q <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            ex_rs_addr_q  <= '0;
            ex_rt_addr_q  <= '0;
            ex_wr_addr_q  <= '0;
            ex_ctrl_q     <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_plus4_q <= ex_pc_plus4_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs_addr_q  <= ex_rs_addr_d;
            ex_rt_addr_q  <= ex_rt_addr_d;
            ex_wr_addr_q  <= ex_wr_addr_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc_plus4   = ex_pc_plus4_q;
    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs_addr    = ex_rs_addr_q;
    assign ex_rt_addr    = ex_rt_addr_q;
    assign ex_wr_addr    = ex_wr_addr_q;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign stall_count   = stall_count_q;
    assign flush_count   = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Scoreboard bench for id_ex_stage with a behavioural pipeline model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [31:0]       id_pc_plus4;
    logic [4:0]        id_rs_addr, id_rt_addr, id_rd_addr;
    logic              id_uses_rt;
    logic [31:0]       rd_data1, rd_data2;
    logic [15:0]       id_imm;
    logic              id_sign_ext, id_reg_write, id_mem_read, id_mem_write;
    logic              id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [3:0]        id_alu_op;
    logic              flush;
    logic              hazard_stall, ex_valid;
    logic [31:0]       ex_pc_plus4, ex_a, ex_b, ex_imm;
    logic [4:0]        ex_rs_addr, ex_rt_addr, ex_wr_addr;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic [CNT_W-1:0]  stall_count, flush_count;

    id_ex_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc_plus4   (id_pc_plus4),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rd_addr    (id_rd_addr),
        .id_uses_rt    (id_uses_rt),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .id_imm        (id_imm),
        .id_sign_ext   (id_sign_ext),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_alu_op     (id_alu_op),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .ex_valid      (ex_valid),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_imm        (ex_imm),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .ex_wr_addr    (ex_wr_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc, d1, d2;
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [15:0] imm;
        logic        sext, rw, mr, mw, m2r, as, reg_dst;
        logic [3:0]  op;
        logic        flush;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, wr;
        logic        rw, mr, mw, m2r, as;
        logic [3:0]  op;
        int          sc, fc;
    } exp_t;

    exp_t  m;
    exp_t  st_q[$];
    bit    hz_q[$];
    bit    last_hz;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        id_valid      = s.valid;
        id_pc_plus4   = s.pc;
        id_rs_addr    = s.rs;
        id_rt_addr    = s.rt;
        id_rd_addr    = s.rd;
        id_uses_rt    = s.uses_rt;
        rd_data1      = s.d1;
        rd_data2      = s.d2;
        id_imm        = s.imm;
        id_sign_ext   = s.sext;
        id_reg_write  = s.rw;
        id_mem_read   = s.mr;
        id_mem_write  = s.mw;
        id_mem_to_reg = s.m2r;
        id_alu_src    = s.as;
        id_reg_dst    = s.reg_dst;
        id_alu_op     = s.op;
        flush         = s.flush;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t mk(bit v, int rs, int rt, int rd, bit ut, int d1, int d2,
                                 int imm, bit sx, bit dst, bit mr, bit fl);
        stim_t s;
        s         = '{default: 0};
        s.valid   = v;
        s.pc      = 32'h0000_0404;
        s.rs      = 5'(rs);
        s.rt      = 5'(rt);
        s.rd      = 5'(rd);
        s.uses_rt = ut;
        s.d1      = 32'(d1);
        s.d2      = 32'(d2);
        s.imm     = 16'(imm);
        s.sext    = sx;
        s.reg_dst = dst;
        s.mr      = mr;
        s.m2r     = mr;
        s.as      = mr;
        s.rw      = 1'b1;
        s.op      = 4'h2;
        s.flush   = fl;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.valid   = ($urandom_range(0, 7) != 0);
        s.pc      = $urandom;
        s.d1      = $urandom;
        s.d2      = $urandom;
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.rd      = 5'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom);
        s.imm     = 16'($urandom);
        s.sext    = 1'($urandom);
        s.rw      = 1'($urandom);
        s.mr      = ($urandom_range(0, 2) == 0);
        s.mw      = 1'($urandom);
        s.m2r     = 1'($urandom);
        s.as      = 1'($urandom);
        s.reg_dst = 1'($urandom);
        s.op      = 4'($urandom);
        s.flush   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // Reference: a load in EX whose target an ID source names forces a bubble;
    // a flush always forces a bubble; otherwise ID moves into EX unchanged.
    task automatic cycle(input stim_t s);
        exp_t n;
        bit   hz;
        @(posedge clk);
        #2;
        apply(s);
        hz = s.valid && m.valid && m.mr && (m.wr != 0) &&
             ((m.wr == s.rs) || (s.uses_rt && (m.wr == s.rt)));
        hz_q.push_back(hz && !s.flush);
        n    = '{default: 0};
        n.sc = m.sc;
        n.fc = m.fc;
        if (!s.flush && !hz) begin
            n.valid = s.valid;
            n.pc    = s.pc;
            n.a     = s.d1;
            n.b     = s.d2;
            n.rs    = s.rs;
            n.rt    = s.rt;
            n.wr    = s.reg_dst ? s.rd : s.rt;
            n.imm   = (s.sext && s.imm[15]) ? (32'hFFFF_0000 | 32'(s.imm)) : 32'(s.imm);
            n.rw    = s.rw  & s.valid;
            n.mr    = s.mr  & s.valid;
            n.mw    = s.mw  & s.valid;
            n.m2r   = s.m2r & s.valid;
            n.as    = s.as  & s.valid;
            n.op    = s.valid ? s.op : 4'h0;
        end
        if (hz && !s.flush && n.sc < CMAX) n.sc++;
        if (s.flush && s.valid && n.fc < CMAX) n.fc++;
        m = n;
        st_q.push_back(n);
        last_hz = hz && !s.flush;
    endtask

    // Upstream holds a stalled instruction and re-presents it the next cycle.
    task automatic issue(input stim_t s);
        stim_t r;
        cycle(s);
        if (last_hz) begin
            r       = s;
            r.flush = 1'b0;
            cycle(r);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ex_valid"},    32'(ex_valid),    32'h0);
        chk({tag, "_ex_a"},        ex_a,             32'h0);
        chk({tag, "_ex_b"},        ex_b,             32'h0);
        chk({tag, "_ex_imm"},      ex_imm,           32'h0);
        chk({tag, "_ex_pc"},       ex_pc_plus4,      32'h0);
        chk({tag, "_ex_wr_addr"},  32'(ex_wr_addr),  32'h0);
        chk({tag, "_ex_ctrl"},     32'({ex_reg_write, ex_mem_read, ex_mem_write,
                                        ex_mem_to_reg, ex_alu_src, ex_alu_op}), 32'h0);
        chk({tag, "_stall_count"}, 32'(stall_count), 32'h0);
        chk({tag, "_flush_count"}, 32'(flush_count), 32'h0);
        chk({tag, "_hazard_stall"}, 32'(hazard_stall), 32'h0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        apply(idle());
        m       = '{default: 0};
        last_hz = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (hz_q.size() > 0) chk("hazard_stall", 32'(hazard_stall), 32'(hz_q.pop_front()));
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("ex_valid",      32'(ex_valid),      32'(e.valid));
            chk("ex_pc_plus4",   ex_pc_plus4,        e.pc);
            chk("ex_a",          ex_a,               e.a);
            chk("ex_b",          ex_b,               e.b);
            chk("ex_imm",        ex_imm,             e.imm);
            chk("ex_rs_addr",    32'(ex_rs_addr),    32'(e.rs));
            chk("ex_rt_addr",    32'(ex_rt_addr),    32'(e.rt));
            chk("ex_wr_addr",    32'(ex_wr_addr),    32'(e.wr));
            chk("ex_reg_write",  32'(ex_reg_write),  32'(e.rw));
            chk("ex_mem_read",   32'(ex_mem_read),   32'(e.mr));
            chk("ex_mem_write",  32'(ex_mem_write),  32'(e.mw));
            chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(e.m2r));
            chk("ex_alu_src",    32'(ex_alu_src),    32'(e.as));
            chk("ex_alu_op",     32'(ex_alu_op),     32'(e.op));
            chk("stall_count",   32'(stall_count),   32'(e.sc));
            chk("flush_count",   32'(flush_count),   32'(e.fc));
        end
    end

    initial begin
        m       = '{default: 0};
        last_hz = 1'b0;
        rst     = 1'b1;
        apply(idle());
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Capture with sign- and zero-extended immediates.
        issue(mk(1, 3, 4, 5, 1, 32'h11, 32'h22, 16'hFFF0, 1, 1, 0, 0));
        issue(mk(1, 3, 4, 5, 1, 32'h11, 32'h22, 16'hFFF0, 0, 1, 0, 0));
        // lw $8 then add using $8: one bubble, one stall counted.
        issue(mk(1, 1, 8, 0, 0, 32'h100, 32'h0, 16'h0004, 1, 0, 1, 0));
        issue(mk(1, 8, 2, 3, 1, 32'h33, 32'h44, 16'h0000, 1, 1, 0, 0));
        // lw $0 then a use of $0: no stall.
        issue(mk(1, 1, 0, 0, 0, 32'h100, 32'h0, 16'h0008, 1, 0, 1, 0));
        issue(mk(1, 0, 0, 6, 1, 32'h55, 32'h66, 16'h0000, 1, 1, 0, 0));
        // lw $9 then rt=9 without rt use: no stall.
        issue(mk(1, 1, 9, 0, 0, 32'h100, 32'h0, 16'h000C, 1, 0, 1, 0));
        issue(mk(1, 2, 9, 7, 0, 32'h77, 32'h88, 16'h0010, 1, 0, 0, 0));
        // Load-use coinciding with a flush: flush wins.
        issue(mk(1, 1, 8, 0, 0, 32'h100, 32'h0, 16'h0004, 1, 0, 1, 0));
        issue(mk(1, 8, 2, 3, 1, 32'h33, 32'h44, 16'h0000, 1, 1, 0, 1));
        // Consecutive valid flushes drive flush_count into saturation.
        for (int i = 0; i < 5; i++) begin
            issue(mk(1, i, i, i, 1, i, i, i, 0, 1, 0, 1));
        end

        for (int i = 0; i < 400; i++) issue(rnd());

        issue(mk(1, 3, 4, 5, 1, 32'h1234, 32'h22, 16'h0001, 1, 1, 0, 0));
        reset_mid();

        for (int i = 0; i < 200; i++) issue(rnd());
        repeat (3) issue(idle());
        repeat (3) @(posedge clk);

        if (st_q.size() != 0 || hz_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", st_q.size(), hz_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the MIPS32 core. It sits directly downstream of the register file and consumes its two combinational read ports plus the decoder's control bundle. It registers operands, immediate and control for the EX stage, resolves the destination register, and detects load-use hazards. On a hazard or a branch flush it injects a bubble, and it keeps saturating stall/flush event counters.

Parameters:
DATA_W, 32, operand/immediate width
ADDR_W, 5, register address width
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc_plus4  in  DATA_W  PC+4 of ID instruction
id_rs_addr  in  ADDR_W  rs field (drives register file read port 1)
id_rt_addr  in  ADDR_W  rt field (drives register file read port 2)
id_rd_addr  in  ADDR_W  rd field
id_uses_rt  in  1  instruction reads rt as a source (R-type/store/branch)
rd_data1  in  DATA_W  register file read data, port 1
rd_data2  in  DATA_W  register file read data, port 2
id_imm  in  16  raw immediate
id_sign_ext  in  1  1: sign-extend imm, 0: zero-extend
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decoder controls
id_alu_op  in  4  ALU operation
flush  in  1  kill the instruction entering ID/EX (taken branch/jump)
hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid  out  1  registered valid
ex_pc_plus4, ex_a, ex_b, ex_imm  out  DATA_W  registered PC+4, rs data, rt data, extended immediate
ex_rs_addr, ex_rt_addr, ex_wr_addr  out  ADDR_W  registered source addresses and resolved destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered controls
ex_alu_op  out  4  registered ALU op
stall_count, flush_count  out  CNT_W  saturating event counters

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: all ex_* outputs and both counters go to 0 immediately on rst=1, independent of clk. hazard_stall is 0 while ex_valid=0.
- Register file writes on the falling edge. ID read data therefore already reflects the WB write of the same cycle; this block performs no WB bypass.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_wr_addr != 0) & ((ex_wr_addr == id_rs_addr) | (id_uses_rt & ex_wr_addr == id_rt_addr)).
- hazard_stall = hazard & ~flush. It is purely combinational and has zero latency.
- Next-state priority, evaluated per rising edge:
  1. flush=1: load bubble.
  2. hazard=1: load bubble. The ID instruction is held upstream and re-presented next cycle.
  3. Otherwise: capture ID.
- Bubble: ex_valid and all ex_* control bits (including ex_alu_op) are 0; datapath fields are don't-care but must be driven to 0.
- Capture:
  - ex_valid <= id_valid.
  - Controls are copied, but gated to 0 when id_valid=0.
  - ex_a <= rd_data1, ex_b <= rd_data2.
  - ex_imm <= {16 copies of id_imm[15]} or {16'b0} concatenated with id_imm, per id_sign_ext.
  - ex_wr_addr <= id_reg_dst ? id_rd_addr : id_rt_addr.
- Latency: one cycle from ID inputs to ex_* outputs.
- Counters:
  - stall_count increments on each edge where hazard_stall=1.
  - flush_count increments on each edge where flush=1 & id_valid=1.
  - Both saturate at all-ones; no wrap.
- flush and hazard in the same cycle: flush wins; hazard_stall=0; no stall counted.

Decomposition:
- Shared package `mips_pkg`: ALU_OP_W=4, REG_ADDR_W=5, a zero-register constant, and a control-bundle struct (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op) reused by EX/MEM and MEM/WB.
- One natural sub-module: `load_use_detect`, a purely combinational hazard comparator. The counters stay inline.

Test Plan:
- Reset mid-operation: with ex_valid=1 and ex_a=0x1234, assert rst between edges -> all ex_* and counters read 0 before the next clk edge.
- Capture: rs=3, rt=4, rd=5, rd_data1=0x11, rd_data2=0x22, imm=0xFFF0, sign_ext=1, reg_dst=1 -> next cycle ex_a=0x11, ex_b=0x22, ex_imm=0xFFFFFFF0, ex_wr_addr=5. Repeating with sign_ext=0 gives ex_imm=0x0000FFF0.
- Load-use: lw $8 (mem_read=1, reg_dst=0, rt=8) at cycle n, then add with rs=8 at n+1 -> hazard_stall=1 in n+1; ex_valid=0 after edge n+1; stall_count=1; add captured on edge n+2.
- Zero destination and rt-only use: lw $0 followed by a use of $0 -> no stall. lw $9 followed by an instruction with id_rt_addr=9 and id_uses_rt=0 -> no stall.
- Flush vs hazard same cycle: load-use condition plus flush=1 -> hazard_stall=0; bubble loaded; flush_count+1; stall_count unchanged.
- Saturation: CNT_W=2, 5 consecutive valid flushes -> flush_count=3 and holds at 3.
